// File: rtl/pattern_scheduler_pkg.sv
// Shared constants for the pattern scheduler: pattern indices, per-pattern dwell
// table (in frames) and the encoding of a pending manual request.
package pattern_scheduler_pkg;

   localparam logic [1:0] PAT_0 = 2'd0;
   localparam logic [1:0] PAT_1 = 2'd1;
   localparam logic [1:0] PAT_2 = 2'd2;

   localparam int unsigned DWELL_W = 16;

   localparam logic [DWELL_W-1:0] DWELL_PAT_0 = 16'd240;
   localparam logic [DWELL_W-1:0] DWELL_PAT_1 = 16'd480;
   localparam logic [DWELL_W-1:0] DWELL_PAT_2 = 16'd360;

   typedef enum logic [1:0] {
      PEND_NONE = 2'd0,
      PEND_NEXT = 2'd1,
      PEND_PREV = 2'd2
   } pend_dir_e;

   // Indices beyond the table reuse the pattern-0 dwell so a wider build still times out.
   function automatic logic [DWELL_W-1:0] dwell_frames(input logic [1:0] idx);
      logic [DWELL_W-1:0] result;
      case (idx)
         PAT_0:   result = DWELL_PAT_0;
         PAT_1:   result = DWELL_PAT_1;
         PAT_2:   result = DWELL_PAT_2;
         default: result = DWELL_PAT_0;
      endcase
      return result;
   endfunction

endpackage

// File: rtl/frame_req_sync.sv
// Detects the vsync rising edge (frame origin) and holds the last manual request
// until that origin consumes it; request latency is one cycle.
module frame_req_sync
   import pattern_scheduler_pkg::*;
(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      vsync,
   input  logic      req_next,
   input  logic      req_prev,
   output logic      frame_tick,
   output pend_dir_e pend_dir,
   output logic      req_pending
);

   logic      vsync_q;
   pend_dir_e pend_q;
   pend_dir_e pend_d;

   // vsync_q resets high so a vsync already high out of reset is not an edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vsync_q <= 1'b1;
         pend_q  <= PEND_NONE;
      end else begin
         vsync_q <= vsync;
         pend_q  <= pend_d;
      end
   end

   assign frame_tick = vsync & ~vsync_q;

   // A tick consumes the held request; one arriving on the tick itself survives it.
   always_comb begin
      pend_d = pend_q;
      if (frame_tick) begin
         pend_d = PEND_NONE;
      end
      if (req_next && !req_prev) begin
         pend_d = PEND_NEXT;
      end else if (req_prev && !req_next) begin
         pend_d = PEND_PREV;
      end
   end

   assign pend_dir    = pend_q;
   assign req_pending = (pend_q != PEND_NONE);

endmodule

// File: rtl/pattern_scheduler.sv
// Chooses the active test pattern per frame: manual next/prev requests win, else
// auto-advance on dwell expiry. Registered outputs update one cycle after the tick.
module pattern_scheduler
   import pattern_scheduler_pkg::*;
#(
   parameter int NUM_PATTERNS = 3,
   parameter int FRAME_W      = 10
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    vsync,
   input  logic                    paused,
   input  logic                    auto_en,
   input  logic                    req_next,
   input  logic                    req_prev,
   output logic [1:0]              pattern_select,
   output logic [NUM_PATTERNS-1:0] pattern_enable,
   output logic [NUM_PATTERNS-1:0] next_frame,
   output logic                    switch_pulse,
   output logic [FRAME_W-1:0]      frame_count,
   output logic                    req_pending
);

   localparam logic [1:0] LAST_SEL = 2'(NUM_PATTERNS - 1);

   logic              frame_tick;
   pend_dir_e         pend_dir;

   logic [1:0]         sel_q, sel_d;
   logic [FRAME_W-1:0] cnt_q, cnt_d;
   logic               sw_pulse_q, sw_pulse_d;

   logic [1:0]         sel_inc, sel_dec;
   logic [FRAME_W-1:0] dwell_last;
   logic               do_switch;

   frame_req_sync u_sync (
      .clk         (clk),
      .rst_n       (rst_n),
      .vsync       (vsync),
      .req_next    (req_next),
      .req_prev    (req_prev),
      .frame_tick  (frame_tick),
      .pend_dir    (pend_dir),
      .req_pending (req_pending)
   );

   assign sel_inc    = (sel_q == LAST_SEL) ? 2'd0 : sel_q + 2'd1;
   assign sel_dec    = (sel_q == 2'd0) ? LAST_SEL : sel_q - 2'd1;
   assign dwell_last = FRAME_W'(dwell_frames(sel_q) - 16'd1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sel_q      <= PAT_0;
         cnt_q      <= '0;
         sw_pulse_q <= 1'b0;
      end else begin
         sel_q      <= sel_d;
         cnt_q      <= cnt_d;
         sw_pulse_q <= sw_pulse_d;
      end
   end

   // Manual request beats dwell expiry, so a coinciding pair yields a single switch.
   always_comb begin
      sel_d     = sel_q;
      cnt_d     = cnt_q;
      do_switch = 1'b0;
      if (frame_tick) begin
         case (pend_dir)
            PEND_NEXT: begin
               sel_d     = sel_inc;
               do_switch = 1'b1;
            end
            PEND_PREV: begin
               sel_d     = sel_dec;
               do_switch = 1'b1;
            end
            default: begin
               if (auto_en && !paused) begin
                  if (cnt_q == dwell_last) begin
                     sel_d     = sel_inc;
                     do_switch = 1'b1;
                  end else begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end
            end
         endcase
         if (do_switch) begin
            cnt_d = '0;
         end
      end
      sw_pulse_d = do_switch;
   end

   always_comb begin
      pattern_enable = '0;
      next_frame     = '0;
      for (int i = 0; i < NUM_PATTERNS; i++) begin
         pattern_enable[i] = (sel_q == 2'(i));
         next_frame[i]     = frame_tick && !paused && !do_switch && (sel_q == 2'(i));
      end
   end

   assign pattern_select = sel_q;
   assign frame_count    = cnt_q;
   assign switch_pulse   = sw_pulse_q;

endmodule

// File: tb/tb_pattern_scheduler.sv
// Directed scenarios plus randomized frames, checked cycle by cycle against a
// frame-level reference model of the scheduling rules.
module tb_pattern_scheduler;

   localparam int NP = 3;
   localparam int FW = 10;

   logic          clk = 1'b0;
   logic          rst_n, vsync, paused, auto_en, req_next, req_prev;
   logic [1:0]    pattern_select;
   logic [NP-1:0] pattern_enable, next_frame;
   logic          switch_pulse, req_pending;
   logic [FW-1:0] frame_count;

   int total = 0;
   int bad   = 0;

   int DWELL [NP] = '{240, 480, 360};
   int m_sel, m_cnt, m_pend, m_sw;
   bit m_vs_prev;
   int sw_seen, nf_seen;

   pattern_scheduler #(.NUM_PATTERNS(NP), .FRAME_W(FW)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .vsync          (vsync),
      .paused         (paused),
      .auto_en        (auto_en),
      .req_next       (req_next),
      .req_prev       (req_prev),
      .pattern_select (pattern_select),
      .pattern_enable (pattern_enable),
      .next_frame     (next_frame),
      .switch_pulse   (switch_pulse),
      .frame_count    (frame_count),
      .req_pending    (req_pending)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total++;
      assert (obs === want) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, want);
      end
   endtask

   // One clock: drive at negedge, check combinational next_frame, advance the model, check registers.
   task automatic step(input logic vs, input logic nx, input logic pv);
      bit            tick;
      int            nsel, would_sw;
      logic [NP-1:0] exp_nf;
      @(negedge clk);
      vsync = vs; req_next = nx; req_prev = pv;
      #1;
      tick     = vs && !m_vs_prev;
      nsel     = m_sel;
      would_sw = 0;
      if (tick) begin
         if (m_pend != 0) begin
            nsel = (m_sel + m_pend + NP) % NP;
            would_sw = 1;
         end else if (auto_en && !paused && m_cnt == DWELL[m_sel] - 1) begin
            nsel = (m_sel + 1) % NP;
            would_sw = 1;
         end
      end
      exp_nf = (tick && !paused && would_sw == 0) ? NP'(1 << m_sel) : '0;
      if (rst_n) begin
         chk("next_frame", 32'(next_frame), 32'(exp_nf));
         if (next_frame != '0) nf_seen++;
      end
      if (!rst_n) begin
         m_sel = 0; m_cnt = 0; m_pend = 0; m_sw = 0; m_vs_prev = 1'b1;
      end else begin
         if (would_sw != 0) m_cnt = 0;
         else if (tick && auto_en && !paused) m_cnt++;
         m_sel = nsel;
         m_sw  = would_sw;
         if (tick) m_pend = 0;
         if (nx && !pv) m_pend = 1;
         else if (pv && !nx) m_pend = -1;
         m_vs_prev = vs;
      end
      @(posedge clk);
      #1;
      chk("pattern_select", 32'(pattern_select), 32'(m_sel));
      chk("frame_count",    32'(frame_count),    32'(m_cnt));
      chk("switch_pulse",   32'(switch_pulse),   32'(m_sw));
      chk("req_pending",    32'(req_pending),    32'(m_pend != 0));
      chk("pattern_enable", 32'(pattern_enable), 32'(1 << m_sel));
      if (switch_pulse) sw_seen++;
   endtask

   // kind: 0 none, 1 next, 2 prev, 3 both; req_at indexes the frame's cycles (nlow = tick cycle).
   task automatic frame(input int nlow, input int nhigh, input int req_at, input int kind);
      logic nx, pv;
      for (int k = 0; k < nlow + nhigh; k++) begin
         nx = (k == req_at) && (kind == 1 || kind == 3);
         pv = (k == req_at) && (kind == 2 || kind == 3);
         step(k >= nlow, nx, pv);
      end
   endtask

   task automatic frames(input int n);
      for (int f = 0; f < n; f++) frame($urandom_range(1, 2), $urandom_range(1, 2), -1, 0);
   endtask

   task automatic do_reset(input logic vs);
      rst_n = 1'b0;
      step(vs, 1'b0, 1'b0);
      step(vs, 1'b0, 1'b0);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0; vsync = 1'b1; paused = 1'b0; auto_en = 1'b1;
      req_next = 1'b0; req_prev = 1'b0;
      m_sel = 0; m_cnt = 0; m_pend = 0; m_sw = 0; m_vs_prev = 1'b1;
      sw_seen = 0; nf_seen = 0;

      // Reset state, then vsync already high out of reset must not tick.
      do_reset(1'b1);
      chk("rst_sel", 32'(pattern_select), 0);
      chk("rst_cnt", 32'(frame_count), 0);
      chk("rst_en",  32'(pattern_enable), 1);
      nf_seen = 0;
      step(1'b1, 1'b0, 1'b0);
      chk("rst_no_tick", 32'(nf_seen), 0);
      chk("rst_no_tick_cnt", 32'(frame_count), 0);

      // Auto advance after 240 frames on pattern 0.
      frames(239);
      chk("auto_pre_sel", 32'(pattern_select), 0);
      chk("auto_pre_cnt", 32'(frame_count), 239);
      sw_seen = 0;
      frame(2, 2, -1, 0);
      chk("auto_sel", 32'(pattern_select), 1);
      chk("auto_cnt", 32'(frame_count), 0);
      chk("auto_pulses", 32'(sw_seen), 1);

      // Mid-frame prev from pattern 0 wraps to 2 at the next origin.
      do_reset(1'b0);
      frame(3, 2, 1, 2);
      chk("prev_pending_seen", 32'(pattern_select), 2);
      chk("prev_pending_clr", 32'(req_pending), 0);
      do_reset(1'b0);
      step(1'b0, 1'b0, 1'b1);
      chk("prev_pending", 32'(req_pending), 1);
      step(1'b0, 1'b0, 1'b0);
      chk("prev_hold", 32'(req_pending), 1);
      frame(1, 2, -1, 0);
      chk("prev_sel", 32'(pattern_select), 2);
      chk("prev_clr", 32'(req_pending), 0);

      // Pause at frame_count 50 for 100 frames.
      do_reset(1'b0);
      frames(50);
      paused = 1'b1;
      nf_seen = 0;
      frames(100);
      chk("pause_cnt", 32'(frame_count), 50);
      chk("pause_sel", 32'(pattern_select), 0);
      chk("pause_nf",  32'(nf_seen), 0);
      paused = 1'b0;

      // Manual next coinciding with dwell expiry: one switch only.
      do_reset(1'b0);
      frames(239);
      sw_seen = 0;
      frame(3, 2, 1, 1);
      chk("coinc_sel", 32'(pattern_select), 1);
      chk("coinc_pulses", 32'(sw_seen), 1);

      // Simultaneous next+prev is ignored.
      do_reset(1'b0);
      sw_seen = 0;
      frame(3, 2, 1, 3);
      chk("both_pending", 32'(req_pending), 0);
      chk("both_sel", 32'(pattern_select), 0);
      chk("both_pulses", 32'(sw_seen), 0);

      // Reset aborts a pending request.
      frame(2, 2, 0, 1);
      step(1'b0, 1'b1, 1'b0);
      chk("abort_pre", 32'(req_pending), 1);
      do_reset(1'b0);
      chk("abort_sel", 32'(pattern_select), 0);
      chk("abort_pend", 32'(req_pending), 0);

      // Request on the tick cycle waits for the following tick.
      sw_seen = 0;
      frame(2, 2, 2, 1);
      chk("ontick_pend", 32'(req_pending), 1);
      chk("ontick_sel", 32'(pattern_select), 0);
      frame(2, 2, -1, 0);
      chk("ontick_next_sel", 32'(pattern_select), 1);
      chk("ontick_pulses", 32'(sw_seen), 1);

      // auto_en=0: selection and count hold, next_frame pulses every tick.
      auto_en = 1'b0;
      frames(7);
      nf_seen = 0;
      sw_seen = 0;
      frames(1000);
      chk("manual_sel", 32'(pattern_select), 1);
      chk("manual_cnt", 32'(frame_count), 0);
      chk("manual_nf",  32'(nf_seen), 1000);
      chk("manual_pulses", 32'(sw_seen), 0);

      // Randomized frames with mixed controls and requests.
      for (int f = 0; f < 400; f++) begin
         int nl, nh;
         nl = $urandom_range(1, 3);
         nh = $urandom_range(1, 3);
         paused  = ($urandom_range(0, 3) == 0);
         auto_en = ($urandom_range(0, 3) != 0);
         frame(nl, nh, $urandom_range(0, nl + nh), $urandom_range(0, 5));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
